hexbox_feeder: RTL
==================

# hexbox_feeder

Upstream stage for the hexbox text overlay. Accepts 32-bit values from a producer over a valid/ready handshake and commits them to the displayed value only at frame start, so the overlay never tears. Converts screen coordinates into hexbox-local x/y for a fixed on-screen window. Realigns the returned hexbox pixel with a delayed display-enable for the video mixer.

## Interface
Parameters:
- COLS, 8, character columns of the hexbox (window width = COLS*8 pixels)
- XBITS, $clog2(COLS*8)-1, MSB index of hb_x
- HW, 12, width of hpos/vpos
- X0, 0, window left edge in screen pixels
- Y0, 0, window top edge in screen lines (window height fixed at 16)
- PIX_LAT, 2, cycles from hb_x/hb_y valid to the matching hb_pixel

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hpos  in  HW  current screen column
- vpos  in  HW  current screen line
- de  in  1  display enable for hpos/vpos
- frame_start  in  1  single-cycle strobe, once per frame, outside the active area
- in_valid  in  1  producer has a value
- in_data  in  32  value to display
- in_ready  out  1  feeder can accept in_data
- hb_value  out  32  committed value to hexbox
- hb_x  out  XBITS+1  hexbox-local column
- hb_y  out  4  hexbox-local line
- hb_pixel  in  1  glyph pixel returned by hexbox
- out_pixel  out  1  overlay pixel, aligned with out_de
- out_de  out  1  de delayed to match out_pixel
- commits  out  8  count of committed values, wraps 255->0

## Operation
- One-entry pending buffer: pend_data[31:0] and pend_full.
- in_ready = !pend_full, driven combinationally from the register.
- Accept: in_valid && in_ready gives pend_data <= in_data and pend_full <= 1.
- Commit: frame_start && pend_full gives hb_value <= pend_data, pend_full <= 0, commits <= commits+1.
- frame_start with pend_full=0: no change.
- Accept and frame_start in the same cycle (pend_full=0): the value is buffered only. It commits at the next frame_start, never the same cycle.
- in_ready rises the cycle after a commit. Back-to-back producer values are therefore limited to one per frame.
- Window test: in_win = de && hpos>=X0 && hpos<X0+COLS*8 && vpos>=Y0 && vpos<Y0+16.
  - Compare at HW+1 bits so X0+COLS*8 cannot overflow.
- Coordinate stage (registered, 1 cycle): when in_win, hb_x <= (hpos-X0)[XBITS:0] and hb_y <= (vpos-Y0)[3:0]; otherwise hb_x <= 0 and hb_y <= 0.
- Delay lines: win_d and de_d shift registers of length 1+PIX_LAT, aligning in_win and de with hb_pixel.
- Output stage (registered): out_pixel <= win_d_last && hb_pixel; out_de <= de_d_last.
- hb_pixel is ignored outside the window.

## Timing
- Reset (async assert, sync-safe release): pend_full=0, pend_data=0, hb_value=0, commits=0, hb_x=0, hb_y=0, all delay-line bits 0, out_pixel=0, out_de=0. in_ready=1 during and after reset.
- Reset mid-operation: any pending value is discarded, and the display reverts to 00000000 until the next commit.
- Latency from hpos/vpos/de to out_pixel/out_de: 2+PIX_LAT cycles (4 at default).
- Latency from accept to hb_value: until the first frame_start strictly after the accept cycle, plus 1 cycle.
- in_data is sampled only on the accept cycle. The producer must hold in_valid and in_data until in_ready is seen high.
- commits wraps from 255 to 0 without a flag.

## Test plan
- Reset, then check in_ready=1, hb_value=0, out_pixel=0, out_de=0. Accept 0xDEADBEEF; hb_value stays 0 until frame_start, is 0xDEADBEEF one cycle later, and commits=1.
- Accept 0x12345678, then hold in_valid with 0xCAFEF00D. in_ready stays 0 and the second value is not taken. After frame_start, hb_value=0x12345678, in_ready=1 next cycle, and 0xCAFEF00D is accepted.
- Assert in_valid and frame_start together with the buffer empty. hb_value is unchanged that frame and updates only at the following frame_start.
- X0=100, Y0=50, COLS=8:
  - hpos=100, vpos=50: hb_x=0, hb_y=0.
  - hpos=163, vpos=65: hb_x=63, hb_y=15.
  - hpos=164 or vpos=66: out of window, hb_x=hb_y=0, out_pixel=0 even if hb_pixel=1.
- Drive a de pulse with a model hexbox of PIX_LAT=2. out_de and out_pixel follow exactly 4 cycles later, and out_pixel tracks the model's hb_pixel.
- Accept a value, then pulse rst_n low mid-frame. pend_full=0, hb_value=0, and the next frame_start commits nothing. Perform 256 commits; commits reads 0.

Source files
------------

// File: rtl/hexbox_feeder_if.sv
// Producer-to-feeder valid/ready handshake carrying the 32-bit value to display.
interface hexbox_feeder_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/hexbox_feeder.sv
// Hexbox overlay feeder: frame-synchronous value commit, window-local coordinates,
// and realignment of the returned glyph pixel with a delayed display enable.
module hexbox_feeder #(
  parameter int unsigned COLS    = 8,
  parameter int unsigned XBITS   = $clog2(COLS*8)-1,
  parameter int unsigned HW      = 12,
  parameter int unsigned X0      = 0,
  parameter int unsigned Y0      = 0,
  parameter int unsigned PIX_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HW-1:0]     hpos,
  input  logic [HW-1:0]     vpos,
  input  logic              de,
  input  logic              frame_start,
  hexbox_feeder_if.slave    bus,
  output logic [31:0]       hb_value,
  output logic [XBITS:0]    hb_x,
  output logic [3:0]        hb_y,
  input  logic              hb_pixel,
  output logic              out_pixel,
  output logic              out_de,
  output logic [7:0]        commits
);

  localparam int unsigned XEND = X0 + COLS*8;
  localparam int unsigned YEND = Y0 + 16;
  localparam int unsigned DLEN = 1 + PIX_LAT;

  logic [31:0]     pend_data;
  logic            pend_full;
  logic            accept;
  logic            commit;
  logic            in_win;
  logic [HW:0]     hx;
  logic [HW:0]     vy;
  logic [DLEN-1:0] win_d;
  logic [DLEN-1:0] de_d;

  assign bus.in_ready = !pend_full;
  assign accept       = bus.in_valid && !pend_full;
  assign commit       = frame_start && pend_full;

  // One extra bit keeps X0+COLS*8 from wrapping at the screen edge.
  assign hx     = {1'b0, hpos};
  assign vy     = {1'b0, vpos};
  assign in_win = de &&
                  (hx >= (HW+1)'(X0)) && (hx < (HW+1)'(XEND)) &&
                  (vy >= (HW+1)'(Y0)) && (vy < (HW+1)'(YEND));

  // Pending buffer; a value accepted alongside frame_start waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= 32'd0;
      pend_full <= 1'b0;
      hb_value  <= 32'd0;
      commits   <= 8'd0;
    end else if (accept) begin
      pend_data <= bus.in_data;
      pend_full <= 1'b1;
    end else if (commit) begin
      hb_value  <= pend_data;
      pend_full <= 1'b0;
      commits   <= commits + 8'd1;
    end
  end

  // Coordinate stage and the delay lines that match hexbox pixel latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_x      <= '0;
      hb_y      <= 4'd0;
      win_d     <= '0;
      de_d      <= '0;
      out_pixel <= 1'b0;
      out_de    <= 1'b0;
    end else begin
      if (in_win) begin
        hb_x <= (XBITS+1)'(hpos) - (XBITS+1)'(X0);
        hb_y <= 4'(vpos) - 4'(Y0);
      end else begin
        hb_x <= '0;
        hb_y <= 4'd0;
      end
      win_d     <= {win_d[DLEN-2:0], in_win};
      de_d      <= {de_d[DLEN-2:0], de};
      out_pixel <= win_d[DLEN-1] && hb_pixel;
      out_de    <= de_d[DLEN-1];
    end
  end

endmodule
